// File: rtl/ttt_board_writer_pkg.sv
// Shared types and constants for the tic-tac-toe board writer.
// Cell k sits at board bits [17-2k:16-2k], O in the upper bit.
package ttt_pkg;

   typedef enum logic [1:0] {
      PLAY,
      CHECK,
      WIN,
      DRAW
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_X    = 2'b01;
   localparam logic [1:0] WIN_O    = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   localparam logic [3:0] LINES [8][3] = '{
      '{4'd0, 4'd1, 4'd2},
      '{4'd3, 4'd4, 4'd5},
      '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6},
      '{4'd1, 4'd4, 4'd7},
      '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd4, 4'd6}
   };

   function automatic logic [4:0] o_bit(input logic [3:0] k);
      return 5'd17 - {k, 1'b0};
   endfunction

   function automatic logic [4:0] x_bit(input logic [3:0] k);
      return 5'd16 - {k, 1'b0};
   endfunction

   function automatic logic [1:0] cell_row(input logic [3:0] k);
      logic [3:0] r;
      r = k / 4'd3;
      return r[1:0];
   endfunction

   function automatic logic [1:0] cell_col(input logic [3:0] k);
      logic [3:0] c;
      c = k % 4'd3;
      return c[1:0];
   endfunction

endpackage

// File: rtl/ttt_board_writer_if.sv
// Button inputs and board/status outputs of the board writer.
// The writer is the slave; the button front-end drives as master.
interface ttt_board_writer_if;
   import ttt_pkg::*;

   logic        btn_up;
   logic        btn_down;
   logic        btn_left;
   logic        btn_right;
   logic        btn_place;
   logic        btn_new_game;
   logic [17:0] board;
   logic [3:0]  cursor;
   logic        turn_o;
   logic [3:0]  move_count;
   logic        game_over;
   logic [1:0]  winner;
   logic        place_reject;

   modport master (
      output btn_up, btn_down, btn_left, btn_right,
      output btn_place, btn_new_game,
      input  board, cursor, turn_o, move_count,
      input  game_over, winner, place_reject
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right,
      input  btn_place, btn_new_game,
      output board, cursor, turn_o, move_count,
      output game_over, winner, place_reject
   );

endinterface

// File: rtl/ttt_board_writer_line_detect.sv
// Flags a completed row, column or diagonal in one side's mark plane.
module ttt_line_detect
   import ttt_pkg::*;
(
   input  logic [8:0] i_plane,
   output logic       o_any_line
);

   always_comb begin
      o_any_line = 1'b0;
      for (int l = 0; l < 8; l++) begin
         if (i_plane[LINES[l][0]] &&
             i_plane[LINES[l][1]] &&
             i_plane[LINES[l][2]])
            o_any_line = 1'b1;
      end
   end

endmodule

// File: rtl/ttt_board_writer.sv
// Owns the tic-tac-toe board: cursor, placement, turn and result.
module ttt_board_writer
   import ttt_pkg::*;
#(
   parameter logic       FIRST_O     = 1'b1,
   parameter logic [3:0] CURSOR_HOME = 4'd4
)
(
   input logic              clk,
   input logic              rst_n,
   ttt_board_writer_if.slave bus
);

   state_t      r_state;
   logic [17:0] r_board;
   logic [3:0]  r_cursor;
   logic        r_turn_o;
   logic [3:0]  r_move_count;
   logic        r_game_over;
   logic [1:0]  r_winner;
   logic        r_place_reject;

   logic [8:0]  w_o_plane;
   logic [8:0]  w_x_plane;
   logic [8:0]  w_mover_plane;
   logic        w_any_line;
   logic        w_cell_free;
   logic [1:0]  w_row;
   logic [1:0]  w_col;
   logic [3:0]  w_next_cursor;

   for (genvar k = 0; k < 9; k++) begin : g_plane
      assign w_o_plane[k] = r_board[17-2*k];
      assign w_x_plane[k] = r_board[16-2*k];
   end

   assign w_mover_plane = r_turn_o ? w_o_plane : w_x_plane;
   assign w_cell_free   = !w_o_plane[r_cursor] && !w_x_plane[r_cursor];
   assign w_row         = cell_row(r_cursor);
   assign w_col         = cell_col(r_cursor);

   ttt_line_detect u_line (
      .i_plane    (w_mover_plane),
      .o_any_line (w_any_line)
   );

   // Moves wrap inside the current row or column.
   always_comb begin
      w_next_cursor = r_cursor;
      if (bus.btn_up)
         w_next_cursor = (w_row == 2'd0) ? r_cursor + 4'd6 : r_cursor - 4'd3;
      else if (bus.btn_down)
         w_next_cursor = (w_row == 2'd2) ? r_cursor - 4'd6 : r_cursor + 4'd3;
      else if (bus.btn_left)
         w_next_cursor = (w_col == 2'd0) ? r_cursor + 4'd2 : r_cursor - 4'd1;
      else if (bus.btn_right)
         w_next_cursor = (w_col == 2'd2) ? r_cursor - 4'd2 : r_cursor + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= PLAY;
         r_board        <= '0;
         r_cursor       <= CURSOR_HOME;
         r_turn_o       <= FIRST_O;
         r_move_count   <= '0;
         r_game_over    <= 1'b0;
         r_winner       <= WIN_NONE;
         r_place_reject <= 1'b0;
      end else begin
         r_place_reject <= 1'b0;
         if (bus.btn_new_game) begin
            r_state      <= PLAY;
            r_board      <= '0;
            r_cursor     <= CURSOR_HOME;
            r_turn_o     <= FIRST_O;
            r_move_count <= '0;
            r_game_over  <= 1'b0;
            r_winner     <= WIN_NONE;
         end else begin
            unique case (r_state)
               PLAY: begin
                  if (bus.btn_place) begin
                     if (w_cell_free) begin
                        if (r_turn_o)
                           r_board[o_bit(r_cursor)] <= 1'b1;
                        else
                           r_board[x_bit(r_cursor)] <= 1'b1;
                        if (r_move_count != 4'd9)
                           r_move_count <= r_move_count + 4'd1;
                        r_state <= CHECK;
                     end else begin
                        r_place_reject <= 1'b1;
                     end
                  end else begin
                     r_cursor <= w_next_cursor;
                  end
               end
               CHECK: begin
                  if (w_any_line) begin
                     r_state     <= WIN;
                     r_game_over <= 1'b1;
                     r_winner    <= r_turn_o ? WIN_O : WIN_X;
                  end else if (r_move_count == 4'd9) begin
                     r_state     <= DRAW;
                     r_game_over <= 1'b1;
                     r_winner    <= WIN_DRAW;
                  end else begin
                     r_state  <= PLAY;
                     r_turn_o <= !r_turn_o;
                  end
               end
               WIN, DRAW: begin
               end
            endcase
         end
      end
   end

   assign bus.board        = r_board;
   assign bus.cursor       = r_cursor;
   assign bus.turn_o       = r_turn_o;
   assign bus.move_count   = r_move_count;
   assign bus.game_over    = r_game_over;
   assign bus.winner       = r_winner;
   assign bus.place_reject = r_place_reject;

endmodule
